prmcu_uart_transmitter: RTL and testbench

//  Serialising half of the PRMCU UART: takes parallel words over a valid/ready handshake and drives

---
 rtl/prmcu_uart_transmitter.sv | 260 ++++++++++++++++++++++++++
 tb/tb_prmcu_uart_transmitter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/prmcu_uart_transmitter.sv
// ============================================================================
// prmcu_uart_transmitter
// ----------------------------------------------------------------------------
// Serialising half of the PRMCU UART. Parallel words arrive over a valid/ready
// handshake and leave on tx_o as asynchronous frames:
//   start bit (0), 5..9 data bits LSB first, optional even parity, 1..2 stop
//   bits (1). Every bit lasts D = max(internal_clk_divider_i, 1) clk cycles.
//
// Ports
//   clk                     system clock
//   rst                     asynchronous reset, active low (0 = reset)
//   uart_en, tx_en          global / transmitter enable; both gate in_rdy_o
//   n_parity_bits_i         1 = append an even parity bit
//   n_stop_bits_i           0/1 -> one stop bit, 2/3 -> two stop bits
//   n_data_bits_i           data bits per frame, clamped into 5..9
//   internal_clk_divider_i  clk cycles per bit (0 behaves as 1)
//   in_dat_i / in_vld_i     word to send and its valid flag
//   in_rdy_o                ready; a word transfers when valid & ready at posedge
//   tx_o                    serial line, idles high
//   busy_o                  high while any frame bit is on the line
//   frame_done_o            one-cycle pulse in the last cycle of the last stop bit
//
// The frame format and the divider are sampled together with the word, so
// configuration changes while a frame is on the line never disturb it.
// ============================================================================
module prmcu_uart_transmitter #(
    parameter int DATA_W = 9,
    parameter int DIV_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              uart_en,
    input  logic              tx_en,
    input  logic              n_parity_bits_i,
    input  logic [1:0]        n_stop_bits_i,
    input  logic [3:0]        n_data_bits_i,
    input  logic [DIV_W-1:0]  internal_clk_divider_i,
    input  logic [DATA_W-1:0] in_dat_i,
    input  logic              in_vld_i,
    output logic              in_rdy_o,
    output logic              tx_o,
    output logic              busy_o,
    output logic              frame_done_o
);

    // Frames never carry more than nine data bits.
    localparam int MAX_BITS = 9;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    // ------------------------------------------------------------------------
    // Registered frame context
    // ------------------------------------------------------------------------
    state_t                state_reg,     state_next;
    logic [DIV_W-1:0]      bit_cnt_reg,   bit_cnt_next;
    logic [3:0]            idx_reg,       idx_next;
    logic                  stop_idx_reg,  stop_idx_next;
    logic [MAX_BITS-1:0]   word_reg,      word_next;
    logic [3:0]            last_idx_reg,  last_idx_next;
    logic                  par_en_reg,    par_en_next;
    logic                  two_stop_reg,  two_stop_next;
    logic [DIV_W-1:0]      last_cnt_reg,  last_cnt_next;
    logic                  parity_reg,    parity_next;

    // ------------------------------------------------------------------------
    // Configuration decode for the word that is about to be accepted
    // ------------------------------------------------------------------------
    logic [3:0]            n_clamp;
    logic [MAX_BITS-1:0]   in_word;
    logic [MAX_BITS-1:0]   data_mask;
    logic [MAX_BITS-1:0]   in_word_masked;
    logic [DIV_W-1:0]      div_last;

    always_comb begin
        n_clamp = n_data_bits_i;
        if (n_data_bits_i < 4'd5) begin
            n_clamp = 4'd5;
        end else if (n_data_bits_i > 4'd9) begin
            n_clamp = 4'd9;
        end
    end

    // Last counter value of a bit period; a divider of 0 acts like 1.
    assign div_last = (internal_clk_divider_i == '0) ? '0
                                                     : internal_clk_divider_i - DIV_W'(1);

    // Widen (or truncate) the input word to the nine possible data positions
    // and blank everything at or above the configured data-bit count, so the
    // stored word and its parity only ever see transmitted bits.
    for (genvar gi = 0; gi < MAX_BITS; gi++) begin : g_word
        if (gi < DATA_W) begin : g_in
            assign in_word[gi] = in_dat_i[gi];
        end else begin : g_zero
            assign in_word[gi] = 1'b0;
        end
        assign data_mask[gi]      = (4'(gi) < n_clamp);
        assign in_word_masked[gi] = in_word[gi] & data_mask[gi];
    end

    // ------------------------------------------------------------------------
    // Handshake and status decode
    // ------------------------------------------------------------------------
    logic bit_last;
    logic stop_final;
    logic accept_window;
    logic xfer;
    logic [MAX_BITS-1:0] word_shift;

    assign bit_last   = (bit_cnt_reg == last_cnt_reg);
    assign stop_final = (state_reg == STOP) && bit_last && (stop_idx_reg == two_stop_reg);

    // Words are taken while idle or in the very last cycle of a frame; the
    // latter gives back-to-back frames with no idle gap. Ready is forced low
    // while reset is asserted.
    assign accept_window = (state_reg == IDLE) || stop_final;
    assign in_rdy_o      = rst && uart_en && tx_en && accept_window;
    assign xfer          = in_vld_i && in_rdy_o;

    assign busy_o       = (state_reg != IDLE);
    assign frame_done_o = stop_final;

    assign word_shift = word_reg >> idx_reg;

    always_comb begin
        tx_o = 1'b1;
        case (state_reg)
            IDLE:    tx_o = 1'b1;
            START:   tx_o = 1'b0;
            DATA:    tx_o = word_shift[0];
            PARITY:  tx_o = parity_reg;
            STOP:    tx_o = 1'b1;
            default: tx_o = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        bit_cnt_next  = bit_cnt_reg;
        idx_next      = idx_reg;
        stop_idx_next = stop_idx_reg;
        word_next     = word_reg;
        last_idx_next = last_idx_reg;
        par_en_next   = par_en_reg;
        two_stop_next = two_stop_reg;
        last_cnt_next = last_cnt_reg;
        parity_next   = parity_reg;

        case (state_reg)
            IDLE: begin
                bit_cnt_next = '0;
            end

            START: begin
                if (bit_last) begin
                    bit_cnt_next = '0;
                    idx_next     = 4'd0;
                    state_next   = DATA;
                end else begin
                    bit_cnt_next = bit_cnt_reg + DIV_W'(1);
                end
            end

            DATA: begin
                if (bit_last) begin
                    bit_cnt_next = '0;
                    if (idx_reg == last_idx_reg) begin
                        stop_idx_next = 1'b0;
                        state_next    = par_en_reg ? PARITY : STOP;
                    end else begin
                        idx_next = idx_reg + 4'd1;
                    end
                end else begin
                    bit_cnt_next = bit_cnt_reg + DIV_W'(1);
                end
            end

            PARITY: begin
                if (bit_last) begin
                    bit_cnt_next  = '0;
                    stop_idx_next = 1'b0;
                    state_next    = STOP;
                end else begin
                    bit_cnt_next = bit_cnt_reg + DIV_W'(1);
                end
            end

            STOP: begin
                if (bit_last) begin
                    bit_cnt_next = '0;
                    if (stop_idx_reg == two_stop_reg) begin
                        state_next = IDLE;
                    end else begin
                        stop_idx_next = 1'b1;
                    end
                end else begin
                    bit_cnt_next = bit_cnt_reg + DIV_W'(1);
                end
            end

            default: begin
                state_next   = IDLE;
                bit_cnt_next = '0;
            end
        endcase

        // A transfer overrides whatever the frame logic chose: it can only
        // happen in IDLE or the final stop cycle, and always starts a frame.
        if (xfer) begin
            state_next    = START;
            bit_cnt_next  = '0;
            idx_next      = 4'd0;
            stop_idx_next = 1'b0;
            word_next     = in_word_masked;
            last_idx_next = n_clamp - 4'd1;
            par_en_next   = n_parity_bits_i;
            two_stop_next = n_stop_bits_i[1];
            last_cnt_next = div_last;
            parity_next   = ^in_word_masked;
        end
    end

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= IDLE;
            bit_cnt_reg  <= '0;
            idx_reg      <= 4'd0;
            stop_idx_reg <= 1'b0;
            word_reg     <= '0;
            last_idx_reg <= 4'd0;
            par_en_reg   <= 1'b0;
            two_stop_reg <= 1'b0;
            last_cnt_reg <= '0;
            parity_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            bit_cnt_reg  <= bit_cnt_next;
            idx_reg      <= idx_next;
            stop_idx_reg <= stop_idx_next;
            word_reg     <= word_next;
            last_idx_reg <= last_idx_next;
            par_en_reg   <= par_en_next;
            two_stop_reg <= two_stop_next;
            last_cnt_reg <= last_cnt_next;
            parity_reg   <= parity_next;
        end
    end

endmodule

// File: tb/tb_prmcu_uart_transmitter.sv
// ============================================================================
// tb_prmcu_uart_transmitter
// ----------------------------------------------------------------------------
// Every accepted word pushes its complete expected line waveform (one entry
// per clk cycle: tx level and frame_done flag) onto a queue. A negedge
// monitor pops one entry per cycle and compares tx_o, busy_o, frame_done_o
// and in_rdy_o; an empty queue means the line must be idle. Directed tests
// add frame-length checks against hand-computed cycle counts.
// ============================================================================
module tb_prmcu_uart_transmitter;

    logic       clk = 1'b0;
    logic       rst;
    logic       uart_en;
    logic       tx_en;
    logic       n_parity_bits_i;
    logic [1:0] n_stop_bits_i;
    logic [3:0] n_data_bits_i;
    logic [7:0] internal_clk_divider_i;
    logic [8:0] in_dat_i;
    logic       in_vld_i;
    logic       in_rdy_o;
    logic       tx_o;
    logic       busy_o;
    logic       frame_done_o;

    always #5 clk = ~clk;

    prmcu_uart_transmitter #(.DATA_W(9), .DIV_W(8)) dut (
        .clk                    (clk),
        .rst                    (rst),
        .uart_en                (uart_en),
        .tx_en                  (tx_en),
        .n_parity_bits_i        (n_parity_bits_i),
        .n_stop_bits_i          (n_stop_bits_i),
        .n_data_bits_i          (n_data_bits_i),
        .internal_clk_divider_i (internal_clk_divider_i),
        .in_dat_i               (in_dat_i),
        .in_vld_i               (in_vld_i),
        .in_rdy_o               (in_rdy_o),
        .tx_o                   (tx_o),
        .busy_o                 (busy_o),
        .frame_done_o           (frame_done_o)
    );

    typedef struct packed {
        logic tx;
        logic done;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks      = 0;
    int   n_fail        = 0;
    int   cyc           = 0;
    int   frames_done   = 0;
    int   last_done_cyc = 0;
    int   xfer_cyc      = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Expected per-cycle waveform of one frame, built from the word and the
    // configuration present at the moment of transfer.
    function automatic void push_frame(input logic [8:0] w, input logic [3:0] n,
                                       input logic p, input logic [1:0] s,
                                       input logic [7:0] div);
        int   nb;
        int   d;
        int   sb;
        logic par;
        nb  = (n < 5) ? 5 : ((n > 9) ? 9 : int'(n));
        d   = (div == 0) ? 1 : int'(div);
        sb  = s[1] ? 2 : 1;
        par = 1'b0;
        for (int k = 0; k < d; k++) exp_q.push_back('{tx: 1'b0, done: 1'b0});
        for (int b = 0; b < nb; b++) begin
            par = par ^ w[b];
            for (int k = 0; k < d; k++) exp_q.push_back('{tx: w[b], done: 1'b0});
        end
        if (p) begin
            for (int k = 0; k < d; k++) exp_q.push_back('{tx: par, done: 1'b0});
        end
        for (int k = 0; k < d * sb; k++) begin
            exp_q.push_back('{tx: 1'b1, done: (k == d * sb - 1)});
        end
    endfunction

    // Cycle monitor: compare, then register any transfer happening at the
    // coming posedge so its frame starts with the next monitored cycle.
    always @(negedge clk) begin
        exp_t e;
        logic en;
        cyc++;
        if (!rst) begin
            check("rst_tx",   tx_o,         1'b1);
            check("rst_busy", busy_o,       1'b0);
            check("rst_done", frame_done_o, 1'b0);
            check("rst_rdy",  in_rdy_o,     1'b0);
            exp_q.delete();
        end else begin
            en = uart_en & tx_en;
            if (exp_q.size() == 0) begin
                check("idle_tx",   tx_o,         1'b1);
                check("idle_busy", busy_o,       1'b0);
                check("idle_done", frame_done_o, 1'b0);
                check("idle_rdy",  in_rdy_o,     en);
            end else begin
                e = exp_q.pop_front();
                check("line_tx",   tx_o,         e.tx);
                check("line_busy", busy_o,       1'b1);
                check("line_done", frame_done_o, e.done);
                check("line_rdy",  in_rdy_o,     e.done ? en : 1'b0);
                if (e.done) begin
                    frames_done++;
                    last_done_cyc = cyc;
                    $display("frame %0d complete at cycle %0d", frames_done, cyc);
                end
            end
            if (in_vld_i && in_rdy_o) begin
                push_frame(in_dat_i, n_data_bits_i, n_parity_bits_i,
                           n_stop_bits_i, internal_clk_divider_i);
            end
        end
    end

    task automatic cfg(input int n, input logic p, input int s, input int div);
        n_data_bits_i          = 4'(n);
        n_parity_bits_i        = p;
        n_stop_bits_i          = 2'(s);
        internal_clk_divider_i = 8'(div);
    endtask

    // Offer a word and wait for its transfer; returns #1 after that posedge.
    task automatic send(input logic [8:0] w, input bit keep);
        bit got;
        got      = 1'b0;
        in_dat_i = w;
        in_vld_i = 1'b1;
        for (int i = 0; i < 3000 && !got; i++) begin
            @(negedge clk);
            if (in_rdy_o) begin
                @(posedge clk);
                #1;
                got = 1'b1;
            end
        end
        check("xfer_timeout", got, 1'b1);
        xfer_cyc = cyc;
        if (!keep) in_vld_i = 1'b0;
    endtask

    task automatic wait_idle();
        bit idle;
        idle = 1'b0;
        for (int i = 0; i < 4000 && !idle; i++) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0 && !busy_o) idle = 1'b1;
        end
        check("idle_timeout", idle, 1'b1);
    endtask

    task automatic frame_len(input string tag, input logic [8:0] w, input int len);
        int t0;
        send(w, 1'b0);
        t0 = xfer_cyc;
        wait_idle();
        check(tag, last_done_cyc - t0, len);
    endtask

    initial begin
        int  t0;
        int  f0;
        bit  k;
        rst      = 1'b0;
        uart_en  = 1'b1;
        tx_en    = 1'b1;
        in_vld_i = 1'b0;
        in_dat_i = '0;
        cfg(8, 1'b0, 0, 4);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // 8N1 div 4
        frame_len("len_8n1", 9'h0A5, 40);
        // 7E1 div 3, parity 0 then 1, upper bits set but ignored
        cfg(7, 1'b1, 0, 3);
        frame_len("len_7e1_a", 9'h055, 30);
        frame_len("len_7e1_b", 9'h1D7, 30);
        // 5N2 / clamped 9N2 / clamped 5N2 at div 2
        cfg(5, 1'b0, 2, 2);
        frame_len("len_5n2", 9'h1F5, 16);
        cfg(12, 1'b0, 3, 2);
        frame_len("len_9n2", 9'h1A5, 24);
        cfg(3, 1'b0, 2, 2);
        frame_len("len_3as5", 9'h0AA, 16);
        // Divider 0 behaves as 1
        cfg(8, 1'b0, 0, 0);
        frame_len("len_div0", 9'h03C, 10);

        // Back-to-back with valid held high
        cfg(8, 1'b0, 0, 5);
        f0 = frames_done;
        send(9'h011, 1'b1);
        t0 = xfer_cyc;
        send(9'h022, 1'b1);
        send(9'h033, 1'b0);
        wait_idle();
        check("b2b_len", last_done_cyc - t0, 150);
        check("b2b_frames", frames_done - f0, 3);

        // tx_en dropped mid-DATA
        cfg(8, 1'b0, 0, 4);
        send(9'h05A, 1'b0);
        f0 = frames_done;
        repeat (20) @(posedge clk);
        #1;
        tx_en    = 1'b0;
        in_dat_i = 9'h077;
        in_vld_i = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("txen_frames", frames_done - f0, 1);
        check("txen_rdy", in_rdy_o, 1'b0);
        check("txen_busy", busy_o, 1'b0);
        tx_en = 1'b1;
        send(9'h077, 1'b0);
        wait_idle();

        // Reset mid-DATA
        send(9'h05A, 1'b0);
        f0 = frames_done;
        repeat (20) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("abort_tx", tx_o, 1'b1);
        check("abort_busy", busy_o, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (50) @(posedge clk);
        #1;
        check("abort_frames", frames_done - f0, 0);
        frame_len("len_after_rst", 9'h081, 40);

        // Random formats, dividers, words and handshake gaps
        for (int i = 0; i < 40; i++) begin
            cfg($urandom_range(3, 12), 1'($urandom_range(0, 1)),
                $urandom_range(0, 3), $urandom_range(0, 6));
            k = (i == 39) ? 1'b0 : 1'($urandom_range(0, 1));
            send(9'($urandom), k);
            if (!k && $urandom_range(0, 2) == 0) wait_idle();
        end
        in_vld_i = 1'b0;
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
